// File: rtl/aes_inv_cipher_if.sv
// Ciphertext-in / plaintext-out handshake bundle for aes_inv_cipher.
// master = producer/consumer side, slave = the cipher core.
interface aes_inv_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;

  modport master (output in_valid, ct, out_ready, input in_ready, out_valid, pt);
  modport slave  (input in_valid, ct, out_ready, output in_ready, out_valid, pt);
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES decryptor, one inverse round per cycle; out_valid Nr cycles after accept.
// Single block in flight: in_ready only when idle; pt/out_valid held until out_ready.
// Define AES_INV_CIPHER_ZEROIZE_EN to clear the plaintext register on DONE->IDLE.
module aes_inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:Nr][127:0]    k_sch,
  aes_inv_cipher_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   r, r_nxt;
  logic [127:0] state, state_nxt;
  logic [127:0] rnd;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects the 1/2/4/8 multiples to sum, so 4'b1110 means multiply by 0x0e
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        o[127 - 8*(4*c + rw) -: 8] = inv_sbox(s[127 - 8*(4*((c - rw + 4) % 4) + rw) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm   <= IDLE;
      r     <= 4'd0;
      state <= '0;
    end else begin
      fsm   <= fsm_nxt;
      r     <= r_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    r_nxt     = r;
    state_nxt = state;
    rnd       = inv_sr_sb(state) ^ k_sch[r];
    case (fsm)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = bus.ct ^ k_sch[Nr];
          r_nxt     = 4'(Nr - 1);
          fsm_nxt   = RUN;
        end
      end
      RUN: begin
        if (r == 4'd0) begin
          state_nxt = rnd;
          fsm_nxt   = DONE;
        end else begin
          state_nxt = inv_mix(rnd);
          r_nxt     = r - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_nxt = IDLE;
`ifdef AES_INV_CIPHER_ZEROIZE_EN
          state_nxt = '0;
`else
          state_nxt = state;
`endif
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.pt        = state;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboarded bench for aes_inv_cipher: Nk=4 and Nk=8 instances, FIPS-197 vectors.
module tb_aes_inv_cipher;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT0    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:10][127:0] k4;
  logic [0:14][127:0] k8;
  logic [31:0]      w [60];
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               last_acc = 0;
  exp_t             q4 [$];
  exp_t             q8 [$];

  aes_inv_cipher_if b4 ();
  aes_inv_cipher_if b8 ();

  aes_inv_cipher #(.Nk(4)) u4 (.clk(clk), .rst(rst), .k_sch(k4), .bus(b4));
  aes_inv_cipher #(.Nk(8)) u8 (.clk(clk), .rst(rst), .k_sch(k8), .bus(b8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {SBOX[2047 - 8*int'(t[31:24]) -: 8], SBOX[2047 - 8*int'(t[23:16]) -: 8],
            SBOX[2047 - 8*int'(t[15:8])  -: 8], SBOX[2047 - 8*int'(t[7:0])   -: 8]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic load4(input logic [127:0] key);
    expand({key, 128'h0}, 4);
    for (int r = 0; r <= 10; r++) k4[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load8(input logic [255:0] key);
    expand(key, 8);
    for (int r = 0; r <= 14; r++) k8[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Offers one block; the expectation is queued at the negedge before the accepting edge.
  task automatic send(input bit big, input logic [127:0] c, input logic [127:0] e, input bit hold);
    bit   ok;
    exp_t it;
    ok = 1'b0;
    @(posedge clk); #1;
    if (big) begin b8.ct = c; b8.in_valid = 1'b1; end
    else     begin b4.ct = c; b4.in_valid = 1'b1; end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (big ? b8.in_ready : b4.in_ready) begin
        ok       = 1'b1;
        it.pt    = e;
        it.acc   = cyc + 1;
        last_acc = cyc + 1;
        if (big) q8.push_back(it);
        else     q4.push_back(it);
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready never seen (big=%0d)", big);
    end
    @(posedge clk); #1;
    if (!hold) begin
      if (big) b8.in_valid = 1'b0;
      else     b4.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (q4.size() != 0 || q8.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: outstanding q4=%0d q8=%0d", q4.size(), q8.size());
      q4.delete();
      q8.delete();
    end
  endtask

  // Monitor: each rising out_valid must match the oldest expectation, Nr cycles after accept.
  initial begin
    bit   pv4, pv8;
    exp_t it;
    pv4 = 1'b0;
    pv8 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv4 = 1'b0;
        pv8 = 1'b0;
      end else begin
        if (b4.out_valid && !pv4) begin
          if (q4.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out4: pt %h", b4.pt);
          end else begin
            it = q4.pop_front();
            chk128("pt4", b4.pt, it.pt);
            chk_int("latency4", cyc - it.acc, 10);
          end
        end
        if (b8.out_valid && !pv8) begin
          if (q8.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out8: pt %h", b8.pt);
          end else begin
            it = q8.pop_front();
            chk128("pt8", b8.pt, it.pt);
            chk_int("latency8", cyc - it.acc, 14);
          end
        end
        pv4 = b4.out_valid;
        pv8 = b8.out_valid;
      end
    end
  end

  initial begin
    int  a0;
    bit  found, seen;
    rst          = 1'b1;
    b4.in_valid  = 1'b0; b4.ct = '0; b4.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.ct = '0; b8.out_ready = 1'b1;
    load4(KEY_C1);
    load8(KEY_C3);
    repeat (3) @(negedge clk);
    chk128("rst_pt4", b4.pt, 128'h0);
    chk_int("rst_in_ready4", int'(b4.in_ready), 1);
    chk_int("rst_out_valid4", int'(b4.out_valid), 0);
    chk128("rst_pt8", b8.pt, 128'h0);
    chk_int("rst_in_ready8", int'(b8.in_ready), 1);
    chk_int("rst_out_valid8", int'(b8.out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_int("no_accept_after_rst", int'(b4.in_ready), 1);

    // FIPS-197 C.1 then the post-handshake plaintext register
    send(1'b0, CT_C1, PT0, 1'b0);
    drain();
    @(negedge clk);
    chk_int("idle_in_ready", int'(b4.in_ready), 1);
    chk_int("idle_out_valid", int'(b4.out_valid), 0);
`ifdef AES_INV_CIPHER_ZEROIZE_EN
    chk128("zeroize_pt", b4.pt, 128'h0);
`else
    chk128("retain_pt", b4.pt, PT0);
`endif

    // FIPS-197 C.3 (AES-256)
    send(1'b1, CT_C3, PT0, 1'b0);
    drain();

    // Consumer stall with an ignored in_valid pulse
    b4.out_ready = 1'b0;
    send(1'b0, CT_C1, PT0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (b4.out_valid) found = 1'b1;
    end
    chk_int("stall_out_valid_seen", int'(found), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin b4.in_valid = 1'b1; b4.ct = 128'hdeadbeef_00000000_12345678_9abcdef0; end
      else        b4.in_valid = 1'b0;
      @(negedge clk);
      chk_int("stall_out_valid", int'(b4.out_valid), 1);
      chk_int("stall_in_ready", int'(b4.in_ready), 0);
      chk128("stall_pt", b4.pt, PT0);
    end
    @(posedge clk); #1;
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_int("release_in_ready", int'(b4.in_ready), 1);
    chk_int("release_out_valid", int'(b4.out_valid), 0);

    // Reset in the middle of a run
    send(1'b0, CT_C1, PT0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q4.delete();
    #1;
    chk128("midrun_rst_pt", b4.pt, 128'h0);
    chk_int("midrun_rst_in_ready", int'(b4.in_ready), 1);
    chk_int("midrun_rst_out_valid", int'(b4.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (b4.out_valid) seen = 1'b1;
    end
    chk_int("abandoned_no_out_valid", int'(seen), 0);
    send(1'b0, CT_C1, PT0, 1'b0);
    drain();

    // Back-to-back with in_valid held high and out_ready tied high
    send(1'b0, CT_C1, PT0, 1'b1);
    a0 = last_acc;
    send(1'b0, CT_C1, PT0, 1'b1);
    chk_int("b2b_gap1", last_acc - a0, 12);
    a0 = last_acc;
    send(1'b0, CT_C1, PT0, 1'b0);
    chk_int("b2b_gap2", last_acc - a0, 12);
    drain();

    // Key switch while idle: FIPS-197 appendix B and the all-zero key
    @(negedge clk);
    load4(KEY_B);
    send(1'b0, CT_B, PT_B, 1'b0);
    drain();
    @(negedge clk);
    load4(128'h0);
    send(1'b0, CT_Z, 128'h0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
